// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: fixed-latency MULT/DIV family plus single-cycle MTHI/MTLO.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
    localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] pending;

    logic [63:0] prod_s, prod_u, result;
    logic [31:0] dvd, dvs, q_mag, r_mag, quo, rem;
    logic        sgn, is_long;
    logic [3:0]  n_load;

    // Signed division runs on magnitudes, then restores signs; this also
    // makes 0x80000000 / -1 wrap to 0x80000000 without special casing.
    always_comb begin
        prod_s  = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        prod_u  = {32'd0, src_a} * {32'd0, src_b};
        sgn     = (op == OP_DIV);
        dvd     = (sgn && src_a[31]) ? (~src_a + 32'd1) : src_a;
        dvs     = (sgn && src_b[31]) ? (~src_b + 32'd1) : src_b;
        q_mag   = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
        r_mag   = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
        quo     = (sgn && (src_a[31] ^ src_b[31])) ? (~q_mag + 32'd1) : q_mag;
        rem     = (sgn && src_a[31]) ? (~r_mag + 32'd1) : r_mag;
        is_long = 1'b0;
        n_load  = MUL_N;
        result  = prod_s;
        case (op)
            OP_MULT: begin
                is_long = 1'b1;
                result  = prod_s;
            end
            OP_MULTU: begin
                is_long = 1'b1;
                result  = prod_u;
            end
            OP_DIV, OP_DIVU: begin
                is_long = 1'b1;
                n_load  = DIV_N;
                result  = (src_b == 32'd0) ? {src_a, 32'hFFFF_FFFF} : {rem, quo};
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                is_long = 1'b1;
                result  = {hi, lo} + prod_s;
            end
            OP_MADDU: begin
                is_long = 1'b1;
                result  = {hi, lo} + prod_u;
            end
            OP_MSUB: begin
                is_long = 1'b1;
                result  = {hi, lo} - prod_s;
            end
            OP_MSUBU: begin
                is_long = 1'b1;
                result  = {hi, lo} - prod_u;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pending <= 64'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_long) begin
                            pending <= result;
                            cnt     <= n_load;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else if (op == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                RUN: begin
                    // Requests arriving here are dropped, not queued.
                    if (cnt == 4'd1) begin
                        {hi, lo} <= pending;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cnt      <= 4'd0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide responder for the pipelined MIPS core; sits in the E stage beside the ALU.
- The pipeline controller is the initiator. It issues an op with `start` and stalls any HI/LO-touching instruction in D while `busy`/`start` is high.
- The unit is the responder. It latches operands, counts the fixed latency, then commits HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  op request, sampled at posedge.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 reserved.
- src_a  input  32  rs value (forwarded).
- src_b  input  32  rt value (forwarded).
- busy  output  1  long op in flight.
- done  output  1  one-cycle pulse on the edge HI/LO commit from a long op.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (rst_n=0, async): hi=0, lo=0, busy=0, done=0, counter=0, state IDLE, pending result cleared. Reset mid-operation aborts the op; HI/LO stay 0.
- FSM states:
  - IDLE: accepts requests.
  - RUN: count down.
- Start acceptance:
  - A request is accepted only when start=1 and state=IDLE.
  - start while RUN is ignored entirely: no queueing, no operand latch. The controller must not do this; the bench checks HI/LO are unaffected.
- Long ops (MULT/MULTU/DIV/DIVU, MADD family):
  - At accepting edge k: latch the 64-bit result into a pending register, load counter with N (MULT_CYCLES or DIV_CYCLES), go RUN.
  - busy=1 for cycles after edges k..k+N-1.
  - At edge k+N: hi/lo <= pending, busy<=0, done<=1 for one cycle, go IDLE.
  - A new start is accepted only at the first edge where busy is already 0, i.e. edge k+N+1 earliest. No back-to-back overlap.
- MTHI/MTLO (IDLE only): single-cycle write hi<=src_a or lo<=src_a at the accepting edge. No busy, no done.
- NONE and reserved codes: no effect, even with start=1.
- Arithmetic:
  - MULT: signed 32x32->64, {hi,lo}=product.
  - MULTU: unsigned 32x32->64, {hi,lo}=product.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the dividend's sign.
  - DIVU: unsigned; lo=quotient, hi=remainder.
- Division corner cases:
  - Divide by zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=src_a. Still takes DIV_CYCLES.
  - DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- Operand timing: operands are sampled only on the accepting edge. Later changes to src_a/src_b during RUN have no effect.
- Output timing: hi/lo change only at commit or MT edges. They are registered, with no combinational path from inputs.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 7-10 supported, each with MULT_CYCLES latency.
  - MADD: {hi,lo} += signed product.
  - MADDU: {hi,lo} += unsigned product.
  - MSUB: {hi,lo} -= signed product.
  - MSUBU: {hi,lo} -= unsigned product.
  - Arithmetic is modulo 2^64. The accumulated base is {hi,lo} as of the accepting edge.
- Undefined: op 7-10 are treated as reserved (no effect, busy stays 0).

Test Plan:
- Reset then MULT src_a=32'hFFFFFFFE, src_b=3 -> busy high for exactly 5 cycles; at commit edge hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done pulses once.
- MULTU with the same operands -> hi=32'h00000002, lo=32'hFFFFFFFA after 5 busy cycles.
- DIV -7 (32'hFFFFFFF9) / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF after 10 busy cycles. Then DIVU 7/0 -> lo=32'hFFFFFFFF, hi=7.
- DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0. A MTHI 32'h1234 with start=1 during busy is ignored; MTHI after busy falls -> hi=32'h1234 next edge, busy stays 0.
- MULT 5*6 started, rst_n pulled low in the 3rd busy cycle -> busy=0, hi=lo=0 immediately. No done pulse after release.
- (MDU_MADD_EN) MTLO 10, MTHI 0, then MADD 4*5 -> hi=0, lo=30. MSUBU 1*31 -> {hi,lo}=64'hFFFFFFFF_FFFFFFFF. Without the macro, op=7 leaves hi/lo unchanged and busy=0.
